// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register-file geometry, load funct3 encodings
// and the byte/halfword extension helpers used by the load path.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 32'd5;
    localparam int unsigned XLEN       = 32'd32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data extraction: picks the addressed byte/halfword from an aligned word
// and sign- or zero-extends it; flags funct3 codes that are not loads.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    output logic [XLEN-1:0] data,
    output logic            illegal
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane and halfword lane selection from the offset
    always_comb begin
        byte_s = raw[7:0];
        case (byte_off)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = raw[7:0];
        endcase
        if (byte_off[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
    end

    // Width/sign decode; unknown codes produce zero data and the illegal flag
    always_comb begin
        data    = {XLEN{1'b0}};
        illegal = 1'b0;
        case (funct3)
            F3_LB:   data = ext8(byte_s, 1'b1);
            F3_LBU:  data = ext8(byte_s, 1'b0);
            F3_LH:   data = ext16(half_s, 1'b1);
            F3_LHU:  data = ext16(half_s, 1'b0);
            F3_LW:   data = raw;
            default: begin
                data    = {XLEN{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port driver: arbitrates ALU and load results (load first,
// with an ALU starvation bound) and issues one registered write per transfer.
module reg_writeback
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 32'd4
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_rd,
    input  logic [XLEN-1:0]       i_ld_raw,
    input  logic [2:0]            i_ld_funct3,
    input  logic [1:0]            i_ld_byte_off,
    output logic                  o_wr_en,
    output logic [REG_ADDR_W-1:0] o_wr_addr,
    output logic [XLEN-1:0]       o_wr_data,
    output logic                  o_err,
    output logic [31:0]           o_wr_count
);

    localparam int unsigned     CW         = $clog2(STARVE_MAX + 32'd1);
    localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

    logic [CW-1:0]         starve_r;
    logic [CW-1:0]         starve_nxt_s;
    logic                  alu_grant_s;
    logic                  ld_grant_s;
    logic                  xfer_s;
    logic [REG_ADDR_W-1:0] sel_rd_s;
    logic [XLEN-1:0]       sel_data_s;
    logic                  sel_err_s;
    logic                  wr_en_nxt_s;
    logic [XLEN-1:0]       ld_data_s;
    logic                  ld_illegal_s;

    logic                  wr_en_r;
    logic [REG_ADDR_W-1:0] wr_addr_r;
    logic [XLEN-1:0]       wr_data_r;
    logic                  err_r;
    logic [31:0]           wr_count_r;

    load_extend u_load_extend (
        .raw      (i_ld_raw),
        .funct3   (i_ld_funct3),
        .byte_off (i_ld_byte_off),
        .data     (ld_data_s),
        .illegal  (ld_illegal_s)
    );

    // Grant, payload select and starvation-counter next state
    always_comb begin
        alu_grant_s  = 1'b0;
        ld_grant_s   = 1'b0;
        sel_rd_s     = {REG_ADDR_W{1'b0}};
        sel_data_s   = {XLEN{1'b0}};
        sel_err_s    = 1'b0;
        starve_nxt_s = starve_r;
        if (i_alu_valid && (!i_ld_valid || (starve_r == STARVE_LIM))) begin
            alu_grant_s = 1'b1;
        end else begin
            ld_grant_s = i_ld_valid;
        end
        if (alu_grant_s) begin
            sel_rd_s   = i_alu_rd;
            sel_data_s = i_alu_data;
        end else if (ld_grant_s) begin
            sel_rd_s   = i_ld_rd;
            sel_data_s = ld_data_s;
            sel_err_s  = ld_illegal_s;
        end else begin
            sel_err_s = 1'b0;
        end
        if (!i_alu_valid || alu_grant_s) begin
            starve_nxt_s = {CW{1'b0}};
        end else if (starve_r == STARVE_LIM) begin
            starve_nxt_s = STARVE_LIM;
        end else begin
            starve_nxt_s = starve_r + CW'(1);
        end
    end

    assign xfer_s      = alu_grant_s | ld_grant_s;
    assign wr_en_nxt_s = xfer_s && (sel_rd_s != {REG_ADDR_W{1'b0}});

    // Registered write port; address/data hold when nothing transfers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_r   <= {CW{1'b0}};
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {REG_ADDR_W{1'b0}};
            wr_data_r  <= {XLEN{1'b0}};
            err_r      <= 1'b0;
            wr_count_r <= 32'd0;
        end else begin
            starve_r <= starve_nxt_s;
            wr_en_r  <= wr_en_nxt_s;
            err_r    <= sel_err_s;
            if (xfer_s) begin
                wr_addr_r <= sel_rd_s;
                wr_data_r <= sel_data_s;
            end
            if (wr_en_nxt_s) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign o_alu_ready = alu_grant_s;
    assign o_ld_ready  = ld_grant_s;
    assign o_wr_en     = wr_en_r;
    assign o_wr_addr   = wr_addr_r;
    assign o_wr_data   = wr_data_r;
    assign o_err       = err_r;
    assign o_wr_count  = wr_count_r;

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
- Write-port driver for the 32x32 register file: collects results from the ALU path and the load path, arbitrates them, and produces the single registered write (wr_en/wr_addr/wr_data) that the register file consumes.
- Performs load-data byte/half extraction and sign/zero extension before the write.
- Exposes the registered write as a forwarding source for the decode stage.

Parameters:
- STARVE_MAX, 4, consecutive cycles an ALU result may be refused before it is forced to win arbitration (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_alu_valid  in  1  ALU result present.
- o_alu_ready  out  1  ALU result accepted this cycle.
- i_alu_rd  in  5  ALU destination register.
- i_alu_data  in  32  ALU result.
- i_ld_valid  in  1  load result present.
- o_ld_ready  out  1  load result accepted this cycle.
- i_ld_rd  in  5  load destination register.
- i_ld_raw  in  32  raw aligned memory word.
- i_ld_funct3  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- i_ld_byte_off  in  2  byte offset within the word.
- o_wr_en  out  1  register-file write enable.
- o_wr_addr  out  5  register-file write address.
- o_wr_data  out  32  register-file write data.
- o_err  out  1  one-cycle pulse: illegal load funct3 accepted.
- o_wr_count  out  32  count of writes issued with o_wr_en=1; wraps at 2^32.

Behaviour:
- Reset (async assert, sync release): o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_err=0, o_wr_count=0, starvation counter=0.
- Handshake: a transfer occurs when valid && ready. Ready is combinational from the grant and is never asserted without the matching valid. Sources must hold valid and payload until the transfer, and their valid must not depend on ready.
- The write side never stalls, so at most one source transfers per cycle, and one always transfers whenever any valid is high.
- Arbitration:
  - Load wins by default.
  - The ALU wins if it is the only requester, or if the starvation counter == STARVE_MAX.
- Starvation counter:
  - Increments on cycles with i_alu_valid && !o_alu_ready.
  - Clears on an ALU transfer or when i_alu_valid=0.
  - Saturates at STARVE_MAX.
- Latency: the write appears on o_wr_* exactly 1 cycle after the transfer cycle. o_wr_en is high for exactly one cycle per transfer. Back-to-back transfers produce back-to-back writes.
- rd==0: the transfer completes (ready asserted) but o_wr_en stays 0 and o_wr_count is not incremented. o_wr_addr/o_wr_data still update.
- No transfer in a cycle: o_wr_en=0 next cycle; o_wr_addr/o_wr_data hold.
- Load extraction (combinational on the granted load, registered into o_wr_data):
  - LB/LBU select byte i_ld_byte_off.
  - LH/LHU select the halfword at i_ld_byte_off[1]; i_ld_byte_off[0] is ignored.
  - LW ignores the offset.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Illegal funct3 (011, 110, 111):
  - The transfer completes and o_wr_data=0.
  - o_wr_en follows the normal rd rule.
  - o_err=1 for the same cycle as the write; otherwise o_err=0.
- Forwarding: downstream taps o_wr_en/o_wr_addr/o_wr_data directly. No extra ports.
- Reset mid-stream: any result accepted in the cycle before reset is lost (o_wr_en forced 0). Sources re-present after reset.

Decomposition:
- Shared package riscv_pkg holds:
  - Load funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - REG_ADDR_W=5, XLEN=32.
- One combinational sub-module load_extend (raw, funct3, byte_off -> data, illegal) holds the extraction and extension. Arbitration, counters and output registers stay in reg_writeback.

Test Plan:
- ALU only: alu_rd=5, data=0xDEADBEEF, one-cycle valid -> o_alu_ready same cycle; next cycle o_wr_en=1, addr=5, data=0xDEADBEEF; o_wr_count=1.
- Loads, raw=0x80F07F81:
  - LB off=0 -> 0xFFFFFF81.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80F0.
  - LHU off=1 -> 0x00007F81.
  - LW -> 0x80F07F81.
- Contention: both valid continuously for 10 cycles, STARVE_MAX=4 -> grants L,L,L,L,A repeating; the ALU never waits more than 4 cycles.
- rd=0: ALU rd=0 data=0x1234 -> ready asserted, o_wr_en stays 0, o_wr_count unchanged.
- Illegal funct3=011, rd=7 -> o_wr_en=1, addr=7, data=0, o_err pulses 1 cycle.
- Reset: assert i_rst_n=0 the cycle after an accepted load -> o_wr_en=0 immediately (async), all outputs 0; after release the first new transfer writes normally.
